// File: rtl/sprite_pkg.sv
// Sprite attribute word layout and the line scheduler's state encoding.
package sprite_pkg;

  localparam int LINE_W       = 10;
  localparam int ATTR_EN      = 31;
  localparam int ATTR_FLIP    = 30;
  localparam int ATTR_X       = 20;
  localparam int ATTR_X_W     = 10;
  localparam int ATTR_Y       = 10;
  localparam int ATTR_Y_W     = 10;
  localparam int ATTR_FRAME   = 0;
  localparam int ATTR_FRAME_W = 8;

  localparam int SPRITE_H = 16;
  localparam int ROW_W    = $clog2(SPRITE_H);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EVAL  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAW  = 3'd4,
    S_DONE  = 3'd5
  } sched_state_t;

endpackage

// File: rtl/sprite_line_scheduler.sv
// Walks the sprite attribute table once per scanline and hands each covering
// sprite row to the drawer, one at a time, in ascending index order.
//
// state | meaning
// IDLE  | waiting for line_start
// FETCH | attr_addr presented, RAM read in flight
// EVAL  | attr_q valid, hit test; advances index on miss/skip
// ISSUE | drw_start pulse, hit counter increments
// DRAW  | waiting for drawer done (first cycle ignored); advances index on exit
// DONE  | line_done pulse, busy drops
import sprite_pkg::*;

module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 16,
  localparam int IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_line_start,
  input  logic [LINE_W-1:0]       i_line_num,
  output logic [IDX_W-1:0]        o_attr_addr,
  input  logic [31:0]             i_attr_q,
  output logic                    o_drw_start,
  output logic [ATTR_X_W-1:0]     o_drw_col_base,
  output logic                    o_drw_flip,
  output logic [ATTR_FRAME_W-1:0] o_drw_frame_id,
  output logic [ROW_W-1:0]        o_drw_row_off,
  input  logic                    i_drw_done,
  output logic                    o_busy,
  output logic                    o_line_done,
  output logic                    o_overflow,
  output logic                    o_line_late
);

  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
  localparam logic [LINE_W-1:0] HEIGHT = LINE_W'(SPRITE_H);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_PER_LINE);

  sched_state_t r_state, w_state_next;

  logic [LINE_W-1:0]       r_line;
  logic [IDX_W-1:0]        r_index;
  logic [CNT_W-1:0]        r_count;
  logic                    r_overflow;
  logic                    r_busy;
  logic                    r_armed;
  logic [ATTR_X_W-1:0]     r_col;
  logic                    r_flip;
  logic [ATTR_FRAME_W-1:0] r_frame;
  logic [ROW_W-1:0]        r_row;

  logic                w_en;
  logic [ATTR_Y_W-1:0] w_y;
  logic [LINE_W-1:0]   w_diff;
  logic                w_hit;
  logic                w_full;
  logic                w_last;
  logic                w_attr_unused;

  // Unsigned wrap of line - y handles sprites straddling the bottom edge.
  always_comb begin
    w_en   = i_attr_q[ATTR_EN];
    w_y    = i_attr_q[ATTR_Y +: ATTR_Y_W];
    w_diff = r_line - w_y;
    w_hit  = w_en && (w_diff < HEIGHT);
    w_full = (r_count == CNT_MAX);
    w_last = (r_index == LAST_IDX);
  end

  assign w_attr_unused = ^i_attr_q[9:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_line_start) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_EVAL;
      S_EVAL: begin
        if (w_hit && !w_full) w_state_next = S_ISSUE;
        else if (w_last)      w_state_next = S_DONE;
        else                  w_state_next = S_FETCH;
      end
      S_ISSUE: w_state_next = S_DRAW;
      S_DRAW: begin
        if (r_armed && i_drw_done) w_state_next = w_last ? S_DONE : S_FETCH;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_drw_start = (r_state == S_ISSUE);
    o_line_done = (r_state == S_DONE);
    o_line_late = i_line_start && (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_line     <= '0;
      r_index    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_armed    <= 1'b0;
      r_col      <= '0;
      r_flip     <= 1'b0;
      r_frame    <= '0;
      r_row      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_line_start) begin
            r_line     <= i_line_num;
            r_index    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_EVAL: begin
          if (w_hit && !w_full) begin
            r_col   <= i_attr_q[ATTR_X +: ATTR_X_W];
            r_flip  <= i_attr_q[ATTR_FLIP];
            r_frame <= i_attr_q[ATTR_FRAME +: ATTR_FRAME_W];
            r_row   <= w_diff[ROW_W-1:0];
          end else begin
            if (w_hit) r_overflow <= 1'b1;
            if (!w_last) r_index <= r_index + 1'b1;
          end
        end
        S_ISSUE: begin
          r_count <= r_count + 1'b1;
          r_armed <= 1'b0;
        end
        // Drawer's done only falls the cycle after start, so skip one cycle.
        S_DRAW: begin
          r_armed <= 1'b1;
          if (r_armed && i_drw_done && !w_last) r_index <= r_index + 1'b1;
        end
        S_DONE:  r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_attr_addr    = r_index;
  assign o_drw_col_base = r_col;
  assign o_drw_flip     = r_flip;
  assign o_drw_frame_id = r_frame;
  assign o_drw_row_off  = r_row;
  assign o_busy         = r_busy;
  assign o_overflow     = r_overflow;

endmodule
